// File: rtl/if_fetch_if.sv
// Wishbone classic bus bundle between the fetch unit (master) and memory (slave).
interface if_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding Wishbone read at a time, one
// instruction slot towards decode, with flush/redirect from the branch unit.
module if_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  use_branch,
  input  logic [ADDR_WIDTH-1:0] branch_out,
  input  logic                  stall,
  if_fetch_if.master            wb,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_inst,
  output logic                  if_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  redirect_pending;
  logic                  bus_req;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] target;

  // Redirect = flush carrying a branch; targets are always word aligned.
  assign redirect = flush & use_branch;
  assign target   = {branch_out[ADDR_WIDTH-1:2], 2'b00};

  // Read-only master: cyc/stb come from a register set only while in FETCH.
  assign wb.wb_cyc_o = bus_req;
  assign wb.wb_stb_o = bus_req;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = '1;
  assign wb.wb_adr_o = pc;

  // Fetch FSM; a redirect seen mid-transaction is parked until the ack so
  // the in-flight read can complete cleanly before changing the PC.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      pc               <= PC_ADDR;
      redirect_pending <= 1'b0;
      redirect_pc      <= PC_ADDR;
      if_valid         <= 1'b0;
      if_pc            <= PC_ADDR;
      if_inst          <= '0;
      bus_req          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          bus_req <= 1'b1;
          if (redirect) pc <= target;
        end
        FETCH: begin
          if (wb.wb_ack_i) begin
            bus_req <= 1'b0;
            if (flush || redirect_pending) begin
              // Stale data: drop it and restart from the newest target.
              if (redirect)              pc <= target;
              else if (redirect_pending) pc <= redirect_pc;
              redirect_pending <= 1'b0;
              state            <= IDLE;
            end else begin
              if_inst  <= wb.wb_dat_i;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + ADDR_WIDTH'(4);
              state    <= HOLD;
            end
          end else if (redirect) begin
            redirect_pending <= 1'b1;
            redirect_pc      <= target;
          end
        end
        HOLD: begin
          // Flush wins over stall.
          if (flush) begin
            if_valid <= 1'b0;
            if (redirect) pc <= target;
            state <= IDLE;
          end else if (!stall) begin
            if_valid <= 1'b0;
            bus_req  <= 1'b1;
            state    <= FETCH;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the instruction stream.
module tb_if_fetch;

  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        use_branch;
  logic [31:0] branch_out;
  logic        stall;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  if_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  if_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_ADDR(BOOT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .use_branch (use_branch),
    .branch_out (branch_out),
    .stall      (stall),
    .wb         (wb.master),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_valid   (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction stream as seen by decode.
  logic [31:0] exp_next;   // PC the next presented instruction must have
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] exp_inst;
  logic        cyc_redir;  // redirect observed during the current bus cycle
  int          idle_run;   // consecutive cycles with neither bus nor slot busy

  // Memory contents seen by the fetcher.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == BOOT) mem = 32'h0000_0013;
    else           mem = {a[23:0], a[31:24]} ^ 32'h0f0f_5a13;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("we_low", {31'd0, wb.wb_we_o}, 32'd0);
    chk("sel_ones", {28'd0, wb.wb_sel_o}, 32'hf);
    chk("stb_eq_cyc", {31'd0, wb.wb_stb_o}, {31'd0, wb.wb_cyc_o});
    chk("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
    chk("idle_len", {31'd0, idle_run <= 1}, 32'd1);
    if (exp_valid) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, exp_inst);
      chk("no_cyc_hold", {31'd0, wb.wb_cyc_o}, 32'd0);
    end
    if (wb.wb_cyc_o && !cyc_redir) chk("adr", wb.wb_adr_o, exp_next);
  endtask

  // Check current outputs, apply one cycle of inputs, advance the model,
  // and return at the following falling edge.
  task automatic step(input logic rst, input logic f, input logic ub,
                      input logic [31:0] bo, input logic st, input logic ak);
    logic cyc_now;
    logic redir;
    check_outputs();
    reset_n       = rst;
    flush         = f;
    use_branch    = ub;
    branch_out    = bo;
    stall         = st;
    wb.wb_ack_i   = ak;
    wb.wb_dat_i   = ak ? mem(wb.wb_adr_o) : $urandom;
    cyc_now       = wb.wb_cyc_o;
    redir         = f & ub;
    if (!rst) begin
      exp_valid = 1'b0;
      exp_next  = BOOT;
      exp_pc    = BOOT;
      exp_inst  = 32'd0;
      cyc_redir = 1'b0;
      idle_run  = 0;
    end else begin
      if (!exp_valid && !cyc_now) idle_run++;
      else                        idle_run = 0;
      if (exp_valid) begin
        if (f || !st) exp_valid = 1'b0;
      end else if (cyc_now && ak) begin
        if (!(f || cyc_redir)) begin
          exp_valid = 1'b1;
          exp_pc    = exp_next;
          exp_inst  = mem(exp_next);
          exp_next  = exp_next + 32'd4;
        end
        cyc_redir = 1'b0;
      end else if (cyc_now && redir) begin
        cyc_redir = 1'b1;
      end
      if (redir) exp_next = {bo[31:2], 2'b00};
    end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; use_branch = 1'b0; branch_out = '0; stall = 1'b0;
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;
    exp_valid = 1'b0; exp_next = BOOT; exp_pc = BOOT; exp_inst = '0;
    cyc_redir = 1'b0; idle_run = 0;
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, BOOT);
    chk("rst_if_inst", if_inst, 32'd0);

    // First fetch, ack one cycle after stb
    step(1, 0, 0, 0, 0, 0);
    chk("first_cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
    chk("first_adr", wb.wb_adr_o, 32'h8000_0000);
    step(1, 0, 0, 0, 1, 1);
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("first_pc", if_pc, 32'h8000_0000);
    chk("first_inst", if_inst, 32'h0000_0013);

    // Stall three cycles in HOLD, then release
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 1, 0);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc", if_pc, 32'h8000_0000);
      chk("stall_inst", if_inst, 32'h0000_0013);
      chk("stall_nocyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("resume_cyc", {31'd0, wb.wb_cyc_o}, 32'd1);
    chk("resume_adr", wb.wb_adr_o, 32'h8000_0004);

    // Redirect during FETCH, ack two cycles later
    step(1, 1, 1, 32'h8000_0100, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("redir_discard", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("redir_adr", wb.wb_adr_o, 32'h8000_0100);
    step(1, 0, 0, 0, 1, 1);
    chk("redir_pc", if_pc, 32'h8000_0100);

    // Flush+branch in HOLD while stalled, unaligned target
    step(1, 1, 1, 32'h8000_0203, 1, 0);
    chk("hold_flush_valid", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("align_adr", wb.wb_adr_o, 32'h8000_0200);
    step(1, 0, 0, 0, 1, 1);
    chk("align_pc", if_pc, 32'h8000_0200);

    // Flush without branch in HOLD
    step(1, 1, 0, 32'h1234_5678, 1, 0);
    chk("kill_valid", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("kill_adr", wb.wb_adr_o, 32'h8000_0204);

    // Reset mid-FETCH with a late ack
    step(0, 0, 0, 0, 0, 0);
    chk("midrst_cyc", {31'd0, wb.wb_cyc_o}, 32'd0);
    chk("midrst_valid", {31'd0, if_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 1);
    chk("midrst_valid2", {31'd0, if_valid}, 32'd0);
    chk("midrst_adr", wb.wb_adr_o, 32'h8000_0000);

    // PC wrap at the top of the address space
    step(1, 1, 1, 32'hffff_ffff, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("top_adr", wb.wb_adr_o, 32'hffff_fffc);
    step(1, 0, 0, 0, 0, 1);
    chk("top_pc", if_pc, 32'hffff_fffc);
    step(1, 0, 0, 0, 0, 0);
    chk("wrap_adr", wb.wb_adr_o, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bo;
      if ($urandom_range(3) == 0) bo = 32'hffff_fff0 | 32'($urandom_range(15));
      else                        bo = BOOT | 32'($urandom_range(32'hfff));
      step($urandom_range(63) != 0, $urandom_range(7) == 0, 1'($urandom_range(1)),
           bo, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
